// File: rtl/demux_1x2_8bits.sv
// demux_1x2_8bits: splits one byte stream into two lanes (even positions -> lane 0, odd -> lane 1), each buffered in a FIFO.
// Latency: a byte is readable after its write edge; pop data is registered and appears one edge after the pop.
// Backpressure: none on input; a byte aimed at a full lane is dropped unless that lane pops in the same cycle; almost_full is the throttle hint.
// Optional: define DEMUX_DROP_CNT_EN to add the saturating drop_cnt output.
module demux_1x2_8bits #(
  parameter int FIFO_DEPTH = 4,
  parameter int AF_THRESH  = 3
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       pop0,
  input  logic       pop1,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       empty0,
  output logic       empty1,
  output logic       full0,
  output logic       full1,
`ifdef DEMUX_DROP_CNT_EN
  output logic [7:0] drop_cnt,
`endif
  output logic       almost_full
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  logic          sel_q, sel_d;
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [CW-1:0] occ_q [2];
  logic [CW-1:0] occ_d [2];
  logic [7:0]    mem_q [2][FIFO_DEPTH];
  logic [7:0]    dout_q [2];
  logic [7:0]    dout_d [2];
  logic [1:0]    vout_q, vout_d;
  logic [1:0]    pop_v, pop_ok, push_ok, full_v, empty_v;

  // Next-state: lane selection, push/pop acceptance, pointer and occupancy updates
  always_comb begin
    pop_v  = {pop1, pop0};
    sel_d  = valid_in ? ~sel_q : sel_q;
    vout_d = '0;
    for (int l = 0; l < 2; l++) begin
      empty_v[l]  = (occ_q[l] == '0);
      full_v[l]   = (occ_q[l] == DEPTH_C);
      // A pop on an empty lane is ignored, even if a push lands there this cycle
      pop_ok[l]   = pop_v[l] & ~empty_v[l];
      // A full lane still accepts a push when it pops in the same cycle
      push_ok[l]  = valid_in && (sel_q == 1'(l)) && (!full_v[l] || pop_ok[l]);
      wr_ptr_d[l] = push_ok[l] ? wr_ptr_q[l] + 1'b1 : wr_ptr_q[l];
      rd_ptr_d[l] = pop_ok[l] ? rd_ptr_q[l] + 1'b1 : rd_ptr_q[l];
      occ_d[l]    = occ_q[l] + CW'(push_ok[l]) - CW'(pop_ok[l]);
      dout_d[l]   = pop_ok[l] ? mem_q[l][rd_ptr_q[l]] : dout_q[l];
      vout_d[l]   = pop_ok[l];
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      sel_q  <= 1'b0;
      vout_q <= '0;
      for (int l = 0; l < 2; l++) begin
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        occ_q[l]    <= '0;
        dout_q[l]   <= 8'h00;
      end
    end else begin
      sel_q  <= sel_d;
      vout_q <= vout_d;
      for (int l = 0; l < 2; l++) begin
        wr_ptr_q[l] <= wr_ptr_d[l];
        rd_ptr_q[l] <= rd_ptr_d[l];
        occ_q[l]    <= occ_d[l];
        dout_q[l]   <= dout_d[l];
      end
    end
  end

  // FIFO storage; no reset needed since pointers/occupancy define validity
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (reset_L && push_ok[l]) begin
        mem_q[l][wr_ptr_q[l]] <= data_in;
      end
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  logic       drop;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Drop detection and saturating drop counter next-state
  always_comb begin
    drop       = valid_in && full_v[sel_q] && !pop_ok[sel_q];
    drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  // Drop counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign data_out0   = dout_q[0];
  assign data_out1   = dout_q[1];
  assign valid_out0  = vout_q[0];
  assign valid_out1  = vout_q[1];
  assign empty0      = empty_v[0];
  assign empty1      = empty_v[1];
  assign full0       = full_v[0];
  assign full1       = full_v[1];
  assign almost_full = (occ_q[0] >= AF_C) || (occ_q[1] >= AF_C);

endmodule

// File: tb/tb_demux_1x2_8bits.sv
// tb_demux_1x2_8bits: directed stimulus with a queue-based reference model checked every cycle.
// Latency: outputs compared on the falling edge after each rising edge.
// Backpressure: exercises full-lane drops and push/pop collisions.
module tb_demux_1x2_8bits;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in, pop0, pop1;
  logic [7:0] data_out0, data_out1;
  logic       valid_out0, valid_out1, empty0, empty1, full0, full1, almost_full;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  demux_1x2_8bits #(.FIFO_DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .pop0(pop0), .pop1(pop1),
    .data_out0(data_out0), .data_out1(data_out1),
    .valid_out0(valid_out0), .valid_out1(valid_out1),
    .empty0(empty0), .empty1(empty1), .full0(full0), .full1(full1),
`ifdef DEMUX_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  // Reference model: two byte queues, a position-parity selector, registered read outputs
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         m_sel, m_live, a0, a1, m_v0, m_v1;
  logic [7:0] m_d0, m_d1;
  int         m_drop;

  always @(posedge clk) begin
    if (!reset_L) begin
      q0.delete(); q1.delete();
      m_sel = 0; m_v0 = 0; m_v1 = 0; m_d0 = 8'h00; m_d1 = 8'h00; m_drop = 0;
      m_live = 1;
    end else begin
      a0 = pop0 && (q0.size() != 0);
      a1 = pop1 && (q1.size() != 0);
      if (a0) m_d0 = q0.pop_front();
      if (a1) m_d1 = q1.pop_front();
      m_v0 = a0;
      m_v1 = a1;
      if (valid_in) begin
        if (!m_sel) begin
          if (q0.size() < DEPTH) q0.push_back(data_in);
          else if (m_drop != 255) m_drop++;
        end else begin
          if (q1.size() < DEPTH) q1.push_back(data_in);
          else if (m_drop != 255) m_drop++;
        end
        m_sel = !m_sel;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (m_live) begin
      chk("m_data_out0", 32'(data_out0), 32'(m_d0));
      chk("m_data_out1", 32'(data_out1), 32'(m_d1));
      chk("m_valid_out0", 32'(valid_out0), 32'(m_v0));
      chk("m_valid_out1", 32'(valid_out1), 32'(m_v1));
      chk("m_empty0", 32'(empty0), 32'(q0.size() == 0));
      chk("m_empty1", 32'(empty1), 32'(q1.size() == 0));
      chk("m_full0", 32'(full0), 32'(q0.size() == DEPTH));
      chk("m_full1", 32'(full1), 32'(q1.size() == DEPTH));
      chk("m_almost_full", 32'(almost_full), 32'((q0.size() >= AF) || (q1.size() >= AF)));
`ifdef DEMUX_DROP_CNT_EN
      chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    end
  end

  // Drive one cycle of inputs, then return on the following falling edge
  task automatic step(input logic rn, input logic v, input logic [7:0] d,
                      input logic p0, input logic p1);
    reset_L = rn; valid_in = v; data_in = d; pop0 = p0; pop1 = p1;
    @(negedge clk);
  endtask

  initial begin
    reset_L = 1'b0; valid_in = 1'b0; data_in = 8'h00; pop0 = 1'b0; pop1 = 1'b0;
    @(negedge clk);
    step(0, 0, 8'h00, 0, 0);
    chk("rst_empty0", 32'(empty0), 32'd1);
    chk("rst_full1", 32'(full1), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_dout0", 32'(data_out0), 32'h00);

    // Stream 10..17: even positions to lane 0, odd to lane 1
    for (int i = 0; i < 8; i++) step(1, 1, 8'(8'h10 + i), 0, 0);
    chk("fill_full0", 32'(full0), 32'd1);
    chk("fill_full1", 32'(full1), 32'd1);
    chk("fill_af", 32'(almost_full), 32'd1);

    // Two bytes into full lanes are dropped
    step(1, 1, 8'h18, 0, 0);
    step(1, 1, 8'h19, 0, 0);
`ifdef DEMUX_DROP_CNT_EN
    chk("drop_cnt_2", 32'(drop_cnt), 32'd2);
`endif

    // Drain lane 0 in order, then pop on empty
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 8'h00, 1, 0);
      chk("pop0_data", 32'(data_out0), 32'(8'h10 + 2 * i));
      chk("pop0_valid", 32'(valid_out0), 32'd1);
    end
    step(1, 0, 8'h00, 1, 0);
    chk("pop0_empty_valid", 32'(valid_out0), 32'd0);
    chk("pop0_empty_hold", 32'(data_out0), 32'h16);
    chk("pop0_empty_flag", 32'(empty0), 32'd1);

    // Full lane 1: push AA with a simultaneous pop
    step(1, 1, 8'h20, 0, 0);
    step(1, 1, 8'hAA, 0, 1);
    chk("fullpp_data1", 32'(data_out1), 32'h11);
    chk("fullpp_valid1", 32'(valid_out1), 32'd1);
    chk("fullpp_full1", 32'(full1), 32'd1);
`ifdef DEMUX_DROP_CNT_EN
    chk("fullpp_nodrop", 32'(drop_cnt), 32'd2);
`endif

    // Empty lane 0: push 55 with a simultaneous pop, no bypass
    step(1, 0, 8'h00, 1, 0);
    chk("pop0_20", 32'(data_out0), 32'h20);
    step(1, 1, 8'h55, 1, 0);
    chk("emptypp_valid0", 32'(valid_out0), 32'd0);
    chk("emptypp_empty0", 32'(empty0), 32'd0);
    step(1, 0, 8'h00, 1, 0);
    chk("emptypp_data0", 32'(data_out0), 32'h55);

    // Load lane 0 with 3 bytes ending with sel=1, then reset mid-stream
    for (int i = 0; i < 6; i++) step(1, 1, 8'(8'h60 + i), 0, 0);
    chk("pre_rst_af", 32'(almost_full), 32'd1);
    step(0, 1, 8'h77, 1, 1);
    chk("mid_rst_empty0", 32'(empty0), 32'd1);
    chk("mid_rst_empty1", 32'(empty1), 32'd1);
    chk("mid_rst_dout0", 32'(data_out0), 32'h00);
    chk("mid_rst_dout1", 32'(data_out1), 32'h00);
    chk("mid_rst_af", 32'(almost_full), 32'd0);
`ifdef DEMUX_DROP_CNT_EN
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
`endif
    step(1, 1, 8'h88, 0, 0);
    chk("post_rst_lane0", 32'(empty0), 32'd0);
    chk("post_rst_lane1", 32'(empty1), 32'd1);
    step(1, 0, 8'h00, 1, 0);
    chk("post_rst_data0", 32'(data_out0), 32'h88);
    step(1, 0, 8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_1x2_8bits.md
# demux_1x2_8bits

Byte-stream splitter for the PCIe physical-layer lane path: accepts one 8-bit stream with a valid qualifier and distributes accepted bytes alternately to lane 0 and lane 1. Each lane has its own small FIFO with a pop handshake. This is the transmit-side counterpart of the 2:1 lane-merging mux. Even-position bytes go to lane 0 and odd-position bytes to lane 1, so a downstream 2:1 merger reconstructs the original order.

## Interface
- FIFO_DEPTH, 4, entries per lane FIFO; power of two, ≥2
- AF_THRESH, 3, per-lane occupancy at or above which almost_full asserts; 1..FIFO_DEPTH
- clk  in  1  single clock; all logic on rising edge
- reset_L  in  1  synchronous, active-low reset, sampled on rising clk
- data_in  in  8  input byte
- valid_in  in  1  data_in carries a byte this cycle
- pop0 / pop1  in  1  request to read one byte from lane 0 / lane 1 FIFO
- data_out0 / data_out1  out  8  registered read data per lane
- valid_out0 / valid_out1  out  1  data_outN valid this cycle (one-cycle pulse per successful pop)
- empty0 / empty1  out  1  lane FIFO holds 0 entries
- full0 / full1  out  1  lane FIFO holds FIFO_DEPTH entries
- almost_full  out  1  either lane occupancy ≥ AF_THRESH (upstream throttle hint)
- drop_cnt  out  8  saturating count of dropped bytes (present only with DEMUX_DROP_CNT_EN)

## Operation
- Internal lane selector sel (1 bit), reset 0. It toggles on every cycle with valid_in=1, whether the byte is stored or dropped, so lane parity always equals stream position parity. It holds when valid_in=0.
- Write: valid_in=1 writes data_in into FIFO[sel] at its write pointer. The pointer increments modulo FIFO_DEPTH.
- Drop: if FIFO[sel] is full and pop for that lane is not accepted in the same cycle, the byte is discarded. The FIFO contents and pointers are unchanged, and sel still toggles.
- Read: popN=1 with emptyN=0 loads the head entry into data_outN, sets valid_outN=1 next cycle, and advances the read pointer modulo FIFO_DEPTH.
- Pop on empty is ignored: valid_outN=0 and data_outN holds its last value.
- Simultaneous push and pop, same lane:
  - FIFO full: both succeed, occupancy unchanged, no drop.
  - FIFO empty: the pop is ignored. There is no bypass; the byte is stored and occupancy becomes 1.
- Occupancy counter per lane is $clog2(FIFO_DEPTH)+1 bits wide and never exceeds FIFO_DEPTH.
- emptyN, fullN and almost_full are decoded combinationally from registered occupancy. They reflect state after the previous edge.
- The lanes are independent. A pop on one lane never affects the other lane.

## Timing
- Reset (reset_L=0 at a rising edge) sets:
  - sel=0, all pointers and occupancies 0
  - data_out0/1=8'h00, valid_out0/1=0
  - empty0/1=1, full0/1=0, almost_full=0, drop_cnt=0
- Reset mid-operation discards all stored bytes. Inputs in the reset cycle are ignored.
- Push latency: a byte accepted at edge N is visible as emptyN=0 after edge N.
- Pop latency: pop sampled at edge N gives data_out/valid_out valid after edge N (registered, 1 cycle).
- Minimum byte-through latency: 2 edges (write edge, then pop edge).
- Sustained throughput: one byte per clock on input; each lane drains at one byte per clock.

## Configuration
- DEMUX_DROP_CNT_EN defined:
  - drop_cnt port and an 8-bit register exist.
  - The register increments once per dropped byte and saturates at 8'hFF.
  - It clears only on reset.
- Undefined: no drop_cnt port and no counter logic. Drop behaviour is otherwise identical.

## Test plan
- Reset then stream 8'h10..8'h17 with valid_in=1 every cycle, no pops -> lane 0 holds 10,12,14,16; lane 1 holds 11,13,15,17; full0=full1=1; almost_full=1.
- Continue from previous: push 8'h18, 8'h19 with no pops -> both dropped, sel back to 0, FIFO contents unchanged; drop_cnt=2 with macro.
- Pop0 on four consecutive cycles -> data_out0 = 10,12,14,16 with valid_out0=1 one cycle after each pop; fifth pop0 -> valid_out0=0, data_out0 stays 16, empty0=1.
- Lane 1 full, push byte 8'hAA to lane 1 with pop1 asserted the same cycle -> data_out1=8'h11 next cycle, 8'hAA stored at tail, no drop, full1 stays 1.
- Empty lane 0, valid_in=1 data 8'h55 with pop0=1 same cycle -> valid_out0=0, empty0=0 next cycle; pop0 next -> data_out0=8'h55.
- Assert reset_L=0 for one cycle with 3 bytes in lane 0 and sel=1 -> all outputs at reset values; next byte goes to lane 0.
